// File: rtl/core_launcher.sv
// core_launcher: host-side sequencer that launches NUM_PROGS core runs over the req/ack handshake
// and reports each run's cycle count. `define LAUNCHER_TIMEOUT_EN adds the run timeout (ERR state, error).
module core_launcher #(
  parameter int unsigned NUM_PROGS  = 3,
  parameter int unsigned REQ_CYCLES = 2,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             go,
  input  logic             ack,
  output logic             req,
  output logic [3:0]       prog_idx,
  output logic             busy,
  output logic [CYC_W-1:0] run_cycles,
  output logic             run_valid,
  output logic             batch_done,
  output logic             error
);

  localparam int unsigned ReqW = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam logic [3:0] LastIdx = 4'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_CLR, RUN, REPORT, DONE, ERR
  } stateE;

  stateE            state;
  logic [ReqW-1:0]  reqCnt;
  logic [CYC_W-1:0] cycCnt;
  logic [CYC_W-1:0] cycInc;

  // Run counter sticks at all-ones instead of wrapping.
  assign cycInc = (&cycCnt) ? cycCnt : cycCnt + CYC_W'(1);

`ifdef LAUNCHER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  logic [ToW-1:0] toCnt;
  logic           toHit;

  assign toHit = (toCnt == ToW'(TIMEOUT));
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req        <= 1'b0;
      prog_idx   <= '0;
      busy       <= 1'b0;
      run_cycles <= '0;
      run_valid  <= 1'b0;
      batch_done <= 1'b0;
      reqCnt     <= '0;
      cycCnt     <= '0;
`ifdef LAUNCHER_TIMEOUT_EN
      toCnt      <= '0;
      error      <= 1'b0;
`endif
    end else begin
      run_valid <= 1'b0;
      if (state inside {REQ, WAIT_CLR, RUN}) cycCnt <= cycInc;
`ifdef LAUNCHER_TIMEOUT_EN
      if (state inside {WAIT_CLR, RUN}) toCnt <= toCnt + ToW'(1);
`endif
      case (state)
        IDLE: begin
          if (go) begin
            state  <= REQ;
            busy   <= 1'b1;
            req    <= 1'b1;
            reqCnt <= '0;
            cycCnt <= CYC_W'(1);
          end
        end
        REQ: begin
          if (reqCnt == ReqW'(REQ_CYCLES - 1)) begin
            state <= WAIT_CLR;
            req   <= 1'b0;
`ifdef LAUNCHER_TIMEOUT_EN
            toCnt <= ToW'(1);
`endif
          end else begin
            reqCnt <= reqCnt + ReqW'(1);
          end
        end
        WAIT_CLR: begin
`ifdef LAUNCHER_TIMEOUT_EN
          if (toHit) begin
            state <= ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else
`endif
          // A stale ack from the previous run must drop before a new rise counts.
          if (!ack) state <= RUN;
        end
        RUN: begin
          if (ack) begin
            state      <= REPORT;
            run_cycles <= cycCnt;
            run_valid  <= 1'b1;
          end
`ifdef LAUNCHER_TIMEOUT_EN
          else if (toHit) begin
            state <= ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end
`endif
        end
        REPORT: begin
          if (prog_idx == LastIdx) begin
            state      <= DONE;
            busy       <= 1'b0;
            batch_done <= 1'b1;
          end else begin
            state    <= REQ;
            prog_idx <= prog_idx + 4'd1;
            req      <= 1'b1;
            reqCnt   <= '0;
            cycCnt   <= CYC_W'(1);
          end
        end
        DONE: begin
          if (!go) begin
            state      <= IDLE;
            batch_done <= 1'b0;
            prog_idx   <= '0;
          end
        end
`ifdef LAUNCHER_TIMEOUT_EN
        ERR: ;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_launcher.sv
// tb_core_launcher: randomized self-checking bench for core_launcher; a small core model drives ack
// and the expected run count is derived from the cycles at which req rose and ack rose.
module tb_core_launcher;
  localparam int NP = 3;
  localparam int RC = 2;
  localparam int CW = 16;
  localparam int TO = 20;
  localparam int SAT_W = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic go = 1'b0;
  logic ack = 1'b0;
  logic req, busy, run_valid, batch_done, error;
  logic [3:0] prog_idx;
  logic [CW-1:0] run_cycles;

  logic go2 = 1'b0;
  logic ack2 = 1'b0;
  logic req2, busy2, run_valid2, batch_done2, error2;
  logic [3:0] prog_idx2;
  logic [SAT_W-1:0] run_cycles2;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  core_launcher #(.NUM_PROGS(NP), .REQ_CYCLES(RC), .CYC_W(CW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .go(go), .ack(ack), .req(req), .prog_idx(prog_idx),
    .busy(busy), .run_cycles(run_cycles), .run_valid(run_valid), .batch_done(batch_done),
    .error(error)
  );

  core_launcher #(.NUM_PROGS(1), .REQ_CYCLES(RC), .CYC_W(SAT_W)) dutSat (
    .clock(clock), .reset_n(reset_n), .go(go2), .ack(ack2), .req(req2), .prog_idx(prog_idx2),
    .busy(busy2), .run_cycles(run_cycles2), .run_valid(run_valid2), .batch_done(batch_done2),
    .error(error2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic pulseGo();
    @(posedge clock); #1 go = 1'b1;
    @(posedge clock); #1 go = 1'b0;
  endtask

  // Core model for one run: ack keeps its old level for `stale` cycles after req falls,
  // drops for `low` cycles, then rises and holds. Expected count = ack-rise cycle - req-rise cycle + 1.
  task automatic serveRun(input int stale, input int low, output int expCnt, output int gotCnt,
                          output bit gotValid, output int gotIdx, output bit early,
                          output int reqLen, output bit timedOut);
    int start;
    int c1;
    int guard;
    early = 1'b0; timedOut = 1'b0; reqLen = 0; gotValid = 1'b0; gotCnt = 0; gotIdx = 0; expCnt = 0;
    guard = 0;
    @(negedge clock);
    while (!req && guard < 64) begin @(negedge clock); guard++; end
    if (!req) begin timedOut = 1'b1; return; end
    start = cyc;
    while (req && reqLen < 64) begin reqLen++; @(negedge clock); end
    for (int i = 0; i < stale; i++) begin
      if (i > 0) @(negedge clock);
      if (run_valid) early = 1'b1;
    end
    @(posedge clock); #1 ack = 1'b0;
    for (int i = 0; i < low; i++) begin
      @(negedge clock);
      if (run_valid) early = 1'b1;
    end
    @(posedge clock); #1 ack = 1'b1;
    c1 = cyc;
    expCnt = c1 - start + 1;
    if (expCnt > (1 << CW) - 1) expCnt = (1 << CW) - 1;
    @(negedge clock);
    if (run_valid) early = 1'b1;
    @(negedge clock);
    gotValid = run_valid;
    gotCnt = int'(run_cycles);
    gotIdx = int'(prog_idx);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; go = 1'b0; ack = 1'b0; go2 = 1'b0; ack2 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (req !== 1'b0) $display("FAIL reset_req got=%0b exp=0", req); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
    checks++; if (prog_idx !== 4'd0) $display("FAIL reset_idx got=%0d exp=0", prog_idx); else passed++;
    checks++; if (run_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", run_valid); else passed++;
    checks++; if (batch_done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", batch_done); else passed++;
    checks++; if (run_cycles !== '0) $display("FAIL reset_cycles got=%0d exp=0", run_cycles); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL reset_error got=%0b exp=0", error); else passed++;
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1 go = 1'b1;
    @(negedge clock);
    checks++; if (req !== 1'b0) $display("FAIL go_latency_early got=%0b exp=0", req); else passed++;
    @(posedge clock); #1 go = 1'b0;
    @(negedge clock);
    checks++; if (req !== 1'b1) $display("FAIL go_to_req got=%0b exp=1", req); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL go_busy got=%0b exp=1", busy); else passed++;
    @(posedge clock); #3 reset_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0) $display("FAIL async_req got=%0b exp=0", req); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL async_busy got=%0b exp=0", busy); else passed++;
    checks++; if (prog_idx !== 4'd0) $display("FAIL async_idx got=%0d exp=0", prog_idx); else passed++;
    checks++; if (run_valid !== 1'b0) $display("FAIL async_valid got=%0b exp=0", run_valid); else passed++;
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (req !== 1'b0 || busy !== 1'b0) $display("FAIL post_reset_idle req=%0b busy=%0b exp=0,0", req, busy); else passed++;
    $display("reset: done");
  endtask

  task automatic checkRun(input string name, input int r, input int expCnt, input int gotCnt,
                          input bit gotValid, input int gotIdx, input bit early, input int reqLen,
                          input bit timedOut);
    $display("%s run %0d: valid=%0b cycles=%0d exp=%0d idx=%0d reqLen=%0d", name, r, gotValid, gotCnt, expCnt, gotIdx, reqLen);
  endtask

  task automatic test_single_batch();
    int e, g, idx, rl; bit v, early, tmo;
    pulseGo();
    for (int r = 0; r < NP; r++) begin
      serveRun(1, 10, e, g, v, idx, early, rl, tmo);
      checkRun("single", r, e, g, v, idx, early, rl, tmo);
      checks++; if (tmo !== 1'b0) $display("FAIL single_req_wait run=%0d got=timeout exp=req", r); else passed++;
      checks++; if (rl !== RC) $display("FAIL single_req_len run=%0d got=%0d exp=%0d", r, rl, RC); else passed++;
      checks++; if (early !== 1'b0) $display("FAIL single_early run=%0d got=1 exp=0", r); else passed++;
      checks++; if (v !== 1'b1) $display("FAIL single_valid run=%0d got=%0b exp=1", r, v); else passed++;
      checks++; if (g !== e) $display("FAIL single_cycles run=%0d got=%0d exp=%0d", r, g, e); else passed++;
      checks++; if (idx !== r) $display("FAIL single_idx run=%0d got=%0d exp=%0d", r, idx, r); else passed++;
      checks++; if (busy !== 1'b1) $display("FAIL single_busy run=%0d got=%0b exp=1", r, busy); else passed++;
    end
    @(negedge clock);
    checks++; if (batch_done !== 1'b1) $display("FAIL single_done got=%0b exp=1", batch_done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_done_busy got=%0b exp=0", busy); else passed++;
    checks++; if (run_valid !== 1'b0) $display("FAIL single_pulse_width got=%0b exp=0", run_valid); else passed++;
  endtask

  task automatic test_stale();
    int e, g, idx, rl; bit v, early, tmo;
    pulseGo();
    for (int r = 0; r < NP; r++) begin
      if (r == 0) serveRun(5, 7, e, g, v, idx, early, rl, tmo);
      else serveRun(1, 3, e, g, v, idx, early, rl, tmo);
      checkRun("stale", r, e, g, v, idx, early, rl, tmo);
      checks++; if (tmo !== 1'b0) $display("FAIL stale_req_wait run=%0d got=timeout exp=req", r); else passed++;
      checks++; if (early !== 1'b0) $display("FAIL stale_early run=%0d got=1 exp=0", r); else passed++;
      checks++; if (v !== 1'b1) $display("FAIL stale_valid run=%0d got=%0b exp=1", r, v); else passed++;
      checks++; if (g !== e) $display("FAIL stale_cycles run=%0d got=%0d exp=%0d", r, g, e); else passed++;
    end
    @(negedge clock);
    checks++; if (batch_done !== 1'b1) $display("FAIL stale_done got=%0b exp=1", batch_done); else passed++;
  endtask

  task automatic test_random();
    int e, g, idx, rl, st, lo; bit v, early, tmo;
    for (int b = 0; b < 3; b++) begin
      pulseGo();
      for (int r = 0; r < NP; r++) begin
        st = $urandom_range(1, 4);
        lo = $urandom_range(1, 10);
        serveRun(st, lo, e, g, v, idx, early, rl, tmo);
        checkRun("random", r, e, g, v, idx, early, rl, tmo);
        checks++; if (tmo !== 1'b0) $display("FAIL rand_req_wait b=%0d run=%0d got=timeout exp=req", b, r); else passed++;
        checks++; if (v !== 1'b1 || early !== 1'b0) $display("FAIL rand_valid b=%0d run=%0d got=%0b/%0b exp=1/0", b, r, v, early); else passed++;
        checks++; if (g !== e) $display("FAIL rand_cycles b=%0d run=%0d got=%0d exp=%0d", b, r, g, e); else passed++;
        checks++; if (idx !== r) $display("FAIL rand_idx b=%0d run=%0d got=%0d exp=%0d", b, r, idx, r); else passed++;
      end
      @(negedge clock);
      checks++; if (batch_done !== 1'b1) $display("FAIL rand_done b=%0d got=%0b exp=1", b, batch_done); else passed++;
    end
  endtask

  task automatic test_go_held();
    int e, g, idx, rl; bit v, early, tmo;
    @(posedge clock); #1 go = 1'b1;
    for (int r = 0; r < NP; r++) begin
      serveRun(2, 3, e, g, v, idx, early, rl, tmo);
      checks++; if (g !== e || v !== 1'b1) $display("FAIL held_run run=%0d got=%0d/%0b exp=%0d/1", r, g, v, e); else passed++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (batch_done !== 1'b1 || req !== 1'b0) $display("FAIL held_stay i=%0d got done=%0b req=%0b exp=1,0", i, batch_done, req); else passed++;
    end
    $display("go_held: stayed in DONE with go high");
    @(posedge clock); #1 go = 1'b0;
    @(posedge clock); #1 go = 1'b1;
    @(negedge clock);
    checks++; if (batch_done !== 1'b0) $display("FAIL held_idle_done got=%0b exp=0", batch_done); else passed++;
    checks++; if (prog_idx !== 4'd0) $display("FAIL held_idle_idx got=%0d exp=0", prog_idx); else passed++;
    checks++; if (req !== 1'b0) $display("FAIL held_idle_req got=%0b exp=0", req); else passed++;
    @(posedge clock); #1 go = 1'b0;
    for (int r = 0; r < NP; r++) begin
      serveRun(1, 2, e, g, v, idx, early, rl, tmo);
      checks++; if (idx !== r || g !== e) $display("FAIL held_relaunch run=%0d got idx=%0d cyc=%0d exp idx=%0d cyc=%0d", r, idx, g, r, e); else passed++;
    end
    @(negedge clock);
    checks++; if (batch_done !== 1'b1) $display("FAIL held_relaunch_done got=%0b exp=1", batch_done); else passed++;
  endtask

  task automatic test_saturation();
    int start, c1, e, guard;
    @(posedge clock); #1 go2 = 1'b1;
    @(posedge clock); #1 go2 = 1'b0;
    guard = 0;
    @(negedge clock);
    while (!req2 && guard < 20) begin @(negedge clock); guard++; end
    checks++; if (req2 !== 1'b1) $display("FAIL sat_req got=%0b exp=1", req2); else passed++;
    start = cyc;
    guard = 0;
    while (req2 && guard < 20) begin @(negedge clock); guard++; end
    repeat (40) @(posedge clock);
    #1 ack2 = 1'b1;
    c1 = cyc;
    e = c1 - start + 1;
    if (e > (1 << SAT_W) - 1) e = (1 << SAT_W) - 1;
    @(negedge clock);
    checks++; if (run_valid2 !== 1'b0) $display("FAIL sat_early got=%0b exp=0", run_valid2); else passed++;
    @(negedge clock);
    $display("saturation: valid=%0b cycles=%0d exp=%0d", run_valid2, run_cycles2, e);
    checks++; if (run_valid2 !== 1'b1) $display("FAIL sat_valid got=%0b exp=1", run_valid2); else passed++;
    checks++; if (int'(run_cycles2) !== e) $display("FAIL sat_cycles got=%0d exp=%0d", run_cycles2, e); else passed++;
    @(negedge clock);
    checks++; if (batch_done2 !== 1'b1) $display("FAIL sat_done got=%0b exp=1", batch_done2); else passed++;
  endtask

  task automatic test_timeout();
    int guard;
    @(posedge clock); #1 reset_n = 1'b0; ack = 1'b0; go = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    pulseGo();
    guard = 0;
    @(negedge clock);
    while (req && guard < 20) begin @(negedge clock); guard++; end
    checks++; if (req !== 1'b0) $display("FAIL to_req_fall got=%0b exp=0", req); else passed++;
`ifdef LAUNCHER_TIMEOUT_EN
    repeat (TO - 1) @(negedge clock);
    checks++; if (error !== 1'b0) $display("FAIL to_early got=%0b exp=0", error); else passed++;
    @(negedge clock);
    $display("timeout: error=%0b req=%0b busy=%0b", error, req, busy);
    checks++; if (error !== 1'b1) $display("FAIL to_error got=%0b exp=1", error); else passed++;
    checks++; if (req !== 1'b0) $display("FAIL to_req got=%0b exp=0", req); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL to_busy got=%0b exp=0", busy); else passed++;
    checks++; if (run_valid !== 1'b0) $display("FAIL to_valid got=%0b exp=0", run_valid); else passed++;
    @(posedge clock); #1 go = 1'b1; ack = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (error !== 1'b1 || req !== 1'b0 || run_valid !== 1'b0) $display("FAIL to_sticky got err=%0b req=%0b val=%0b exp=1,0,0", error, req, run_valid); else passed++;
    @(posedge clock); #1 go = 1'b0; ack = 1'b0;
`else
    repeat (30) @(negedge clock);
    $display("timeout: feature off, error=%0b busy=%0b", error, busy);
    checks++; if (error !== 1'b0) $display("FAIL to_off_error got=%0b exp=0", error); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL to_off_busy got=%0b exp=1", busy); else passed++;
    checks++; if (run_valid !== 1'b0) $display("FAIL to_off_valid got=%0b exp=0", run_valid); else passed++;
`endif
    @(posedge clock); #3 reset_n = 1'b0;
    #1;
    checks++; if (error !== 1'b0 || busy !== 1'b0) $display("FAIL to_reset got err=%0b busy=%0b exp=0,0", error, busy); else passed++;
    @(posedge clock); #1 reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_batch();
    test_stale();
    test_random();
    test_go_held();
    test_saturation();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
